rr_dispatch: RTL and testbench

- Round-robin stream dispatcher that sits directly upstream of the 1xN demux stage.
- Accepts one valid/ready input stream and assigns each accepted word to the next output line in rotation (0,1,…,N-1,0,…).
- Holds the word in a one-entry output register until the selected line accepts it.
- Presents the data, the select index, and a one-hot valid vector (the demuxed valid) to the N consumers.

---
 rtl/rr_dispatch_pkg.sv | 18 +
 rtl/rr_ptr.sv | 25 ++
 rtl/rr_dispatch.sv | 69 ++++++
 tb/tb_rr_dispatch.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_dispatch_pkg.sv
// Shared types and helpers for the round-robin dispatcher and its pointer.
package rr_dispatch_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Widest line count the one-hot helper supports; callers cast down to N bits.
    localparam int MAX_N = 64;

    function automatic logic [MAX_N-1:0] onehot(input logic [31:0] idx);
        logic [MAX_N-1:0] one;
        one = MAX_N'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_ptr.sv
// Modulo-N rotation pointer: advances by one per enable and wraps after N-1.
module rr_ptr
    import rr_dispatch_pkg::*;
#(
    parameter int N         = 4,
    parameter int SEL_WIDTH = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    output logic [SEL_WIDTH-1:0] ptr
);

    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(N - 1);

    // Explicit wrap keeps the pointer inside 0..N-1 when N is not a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST) ? '0 : ptr + SEL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rr_dispatch.sv
// Round-robin stream dispatcher: one-entry holding register feeding a 1xN demux.
module rr_dispatch
    import rr_dispatch_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int SEL_WIDTH = $clog2(N),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [W-1:0]         out_data,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic [CNT_W-1:0]     sent_count
);

    state_t               state;
    logic [W-1:0]         data_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [SEL_WIDTH-1:0] ptr;
    logic                 accept;
    logic                 drain;

    // Only the targeted line's ready matters; a stalled target blocks the stream.
    assign in_ready = (state == EMPTY) | out_ready[sel_q];
    assign accept   = in_valid & in_ready;
    assign drain    = (state == FULL) & out_ready[sel_q];

    rr_ptr #(
        .N         (N),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (accept),
        .ptr     (ptr)
    );

    // A simultaneous drain and accept reloads the register, so FULL persists with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            data_q     <= '0;
            sel_q      <= '0;
            sent_count <= '0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                sel_q  <= ptr;
                state  <= FULL;
            end else if (drain) begin
                state <= EMPTY;
            end
            if (drain) begin
                sent_count <= sent_count + CNT_W'(1);
            end
        end
    end

    assign out_valid = (state == FULL) ? N'(onehot(32'(sel_q))) : '0;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_dispatch.sv
// Bench for rr_dispatch: a 4-line/16-bit-count instance and a 3-line/4-bit-count instance.
module tb_rr_dispatch;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid_a = 1'b0;
    logic        in_ready_a;
    logic [7:0]  in_data_a = '0;
    logic [3:0]  out_valid_a;
    logic [3:0]  out_ready_a = '0;
    logic [7:0]  out_data_a;
    logic [1:0]  out_sel_a;
    logic [15:0] sent_count_a;

    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [7:0]  in_data_b = '0;
    logic [2:0]  out_valid_b;
    logic [2:0]  out_ready_b = '0;
    logic [7:0]  out_data_b;
    logic [1:0]  out_sel_b;
    logic [3:0]  sent_count_b;

    int compared = 0;
    int mismatched = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   acc_a = 0;
    int   acc_b = 0;

    always #5 clk = ~clk;

    rr_dispatch #(.N(4), .W(8), .SEL_WIDTH(2), .CNT_W(16)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .in_data    (in_data_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a),
        .out_data   (out_data_a),
        .out_sel    (out_sel_a),
        .sent_count (sent_count_a)
    );

    rr_dispatch #(.N(3), .W(8), .SEL_WIDTH(2), .CNT_W(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .in_data    (in_data_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_data   (out_data_b),
        .out_sel    (out_sel_b),
        .sent_count (sent_count_b)
    );

    // Scoreboard A: expected line comes from the count of accepted words, not from the DUT pointer.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] ev;
        if (!rst_n) begin
            q_a.delete();
            acc_a = 0;
        end else begin
            if ((out_valid_a & out_ready_a) != 4'b0) begin
                compared++;
                if (q_a.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL sb_a_unexpected: got out_valid=%b expected no word", out_valid_a);
                end else begin
                    e  = q_a.pop_front();
                    ev = 4'(1 << e.sel);
                    if (out_data_a !== e.data || out_sel_a !== e.sel || out_valid_a !== ev) begin
                        mismatched++;
                        $display("[TB] FAIL sb_a_word: got data=%h sel=%0d valid=%b expected data=%h sel=%0d valid=%b",
                                 out_data_a, out_sel_a, out_valid_a, e.data, e.sel, ev);
                    end
                end
            end
            if (in_valid_a && in_ready_a) begin
                q_a.push_back('{data: in_data_a, sel: 2'(acc_a % 4)});
                acc_a++;
            end
        end
    end

    // Scoreboard B: three lines, so the expected rotation is the accept count modulo 3.
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] ev;
        if (!rst_n) begin
            q_b.delete();
            acc_b = 0;
        end else begin
            if ((out_valid_b & out_ready_b) != 3'b0) begin
                compared++;
                if (q_b.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL sb_b_unexpected: got out_valid=%b expected no word", out_valid_b);
                end else begin
                    e  = q_b.pop_front();
                    ev = 3'(1 << e.sel);
                    if (out_data_b !== e.data || out_sel_b !== e.sel || out_valid_b !== ev) begin
                        mismatched++;
                        $display("[TB] FAIL sb_b_word: got data=%h sel=%0d valid=%b expected data=%h sel=%0d valid=%b",
                                 out_data_b, out_sel_b, out_valid_b, e.data, e.sel, ev);
                    end
                end
            end
            if (in_valid_b && in_ready_b) begin
                q_b.push_back('{data: in_data_b, sel: 2'(acc_b % 3)});
                acc_b++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        compared++;
        if (out_valid_a !== 4'b0 || in_ready_a !== 1'b1 || sent_count_a !== 16'd0 ||
            out_data_a !== 8'h00 || out_sel_a !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got valid=%b ready=%b count=%0d data=%h sel=%0d expected 0000/1/0/00/0",
                     out_valid_a, in_ready_a, sent_count_a, out_data_a, out_sel_a);
        end
        tick();
        tick();
        rst_n = 1'b1;
        out_ready_a = 4'hF;
        in_valid_a = 1'b1;
        in_data_a = 8'h5A;
        tick();
        in_valid_a = 1'b0;
        compared++;
        if (out_sel_a !== 2'd0 || out_valid_a !== 4'b0001 || out_data_a !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL reset_first_line: got sel=%0d valid=%b data=%h expected 0/0001/5a",
                     out_sel_a, out_valid_a, out_data_a);
        end
        tick();
    endtask

    task automatic test_rotation();
        do_reset();
        out_ready_a = 4'hF;
        for (int i = 0; i < 6; i++) begin
            in_valid_a = 1'b1;
            in_data_a = 8'hA0 + 8'(i);
            #2;
            compared++;
            if (in_ready_a !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL rotation_ready[%0d]: got %b expected 1", i, in_ready_a);
            end
            tick();
            compared++;
            if (out_sel_a !== 2'(i % 4) || out_data_a !== 8'hA0 + 8'(i)) begin
                mismatched++;
                $display("[TB] FAIL rotation_sel[%0d]: got sel=%0d data=%h expected sel=%0d data=%h",
                         i, out_sel_a, out_data_a, i % 4, 8'hA0 + 8'(i));
            end
        end
        in_valid_a = 1'b0;
        tick();
        compared++;
        if (sent_count_a !== 16'd6 || out_valid_a !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL rotation_count: got count=%0d valid=%b expected 6/0000", sent_count_a, out_valid_a);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready_a = 4'b1101;
        in_valid_a = 1'b1;
        in_data_a = 8'h11;
        tick();
        compared++;
        if (out_valid_a !== 4'b0001 || out_data_a !== 8'h11) begin
            mismatched++;
            $display("[TB] FAIL bp_first: got valid=%b data=%h expected 0001/11", out_valid_a, out_data_a);
        end
        in_data_a = 8'h22;
        tick();
        in_data_a = 8'h33;
        for (int c = 0; c < 5; c++) begin
            #2;
            compared++;
            if (out_valid_a !== 4'b0010 || out_data_a !== 8'h22 || out_sel_a !== 2'd1 || in_ready_a !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h sel=%0d ready=%b expected 0010/22/1/0",
                         c, out_valid_a, out_data_a, out_sel_a, in_ready_a);
            end
            tick();
        end
    endtask

    task automatic test_nontarget_ready();
        out_ready_a = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            #2;
            compared++;
            if (out_valid_a !== 4'b0010 || in_ready_a !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL nontarget_hold[%0d]: got valid=%b ready=%b expected 0010/0",
                         c, out_valid_a, in_ready_a);
            end
            tick();
        end
        compared++;
        if (sent_count_a !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL nontarget_count: got %0d expected 1", sent_count_a);
        end
        out_ready_a = 4'b0010;
        #2;
        compared++;
        if (in_ready_a !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_ready: got %b expected 1", in_ready_a);
        end
        tick();
        in_valid_a = 1'b0;
        compared++;
        if (out_valid_a !== 4'b0100 || out_sel_a !== 2'd2 || out_data_a !== 8'h33 || sent_count_a !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL release_next: got valid=%b sel=%0d data=%h count=%0d expected 0100/2/33/2",
                     out_valid_a, out_sel_a, out_data_a, sent_count_a);
        end
        out_ready_a = 4'hF;
        tick();
        compared++;
        if (sent_count_a !== 16'd3 || out_valid_a !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL release_drain: got count=%0d valid=%b expected 3/0000", sent_count_a, out_valid_a);
        end
    endtask

    task automatic test_nonpow2();
        logic [2:0] ev;
        do_reset();
        out_ready_b = 3'b111;
        for (int i = 0; i < 7; i++) begin
            in_valid_b = 1'b1;
            in_data_b = 8'h40 + 8'(i);
            tick();
            ev = 3'(1 << (i % 3));
            compared++;
            if (out_sel_b !== 2'(i % 3) || out_valid_b !== ev) begin
                mismatched++;
                $display("[TB] FAIL n3_sel[%0d]: got sel=%0d valid=%b expected sel=%0d valid=%b",
                         i, out_sel_b, out_valid_b, i % 3, ev);
            end
        end
        in_valid_b = 1'b0;
        tick();
        compared++;
        if (sent_count_b !== 4'd7) begin
            mismatched++;
            $display("[TB] FAIL n3_count: got %0d expected 7", sent_count_b);
        end
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 10; i++) begin
            in_valid_b = 1'b1;
            in_data_b = 8'h50 + 8'(i);
            tick();
        end
        in_valid_b = 1'b0;
        tick();
        compared++;
        if (sent_count_b !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL count_wrap: got %0d expected 1", sent_count_b);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        out_ready_a = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1'b1;
            in_data_a = 8'hC0 + 8'(i);
            tick();
        end
        in_valid_a = 1'b0;
        tick();
        compared++;
        if (out_valid_a !== 4'b1000 || out_sel_a !== 2'd3 || sent_count_a !== 16'd3) begin
            mismatched++;
            $display("[TB] FAIL midreset_held: got valid=%b sel=%0d count=%0d expected 1000/3/3",
                     out_valid_a, out_sel_a, sent_count_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid_a !== 4'b0 || in_ready_a !== 1'b1 || out_sel_a !== 2'd0 || sent_count_a !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_async: got valid=%b ready=%b sel=%0d count=%0d expected 0000/1/0/0",
                     out_valid_a, in_ready_a, out_sel_a, sent_count_a);
        end
        tick();
        rst_n = 1'b1;
        out_ready_a = 4'hF;
        in_valid_a = 1'b1;
        in_data_a = 8'hE5;
        tick();
        in_valid_a = 1'b0;
        compared++;
        if (out_sel_a !== 2'd0 || out_valid_a !== 4'b0001 || out_data_a !== 8'hE5) begin
            mismatched++;
            $display("[TB] FAIL midreset_restart: got sel=%0d valid=%b data=%h expected 0/0001/e5",
                     out_sel_a, out_valid_a, out_data_a);
        end
        tick();
        compared++;
        if (sent_count_a !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL midreset_count: got %0d expected 1", sent_count_a);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_nontarget_ready();
        test_nonpow2();
        test_counter_wrap();
        test_midreset();
        tick();
        compared++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL sb_leftover: got %0d/%0d pending words expected 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
